// File: rtl/int_arb_pkg.sv
// int_pkg: register offsets, gateway state encoding and ID sizing shared by int_arb and int_gateway.
package int_pkg;
  localparam int ID_W = 4;
  localparam logic [7:0] ADDR_PEND  = 8'h40;
  localparam logic [7:0] ADDR_EN    = 8'h44;
  localparam logic [7:0] ADDR_THR   = 8'h48;
  localparam logic [7:0] ADDR_CLAIM = 8'h4C;
  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PEND    = 2'd1,
    GW_CLAIMED = 2'd2
  } gw_state_e;
  function automatic logic [7:0] prio_addr(input int id);
    return 8'(4 * id);
  endfunction
endpackage

// File: rtl/int_arb_gateway.sv
// int_gateway: one source's IDLE/PEND/CLAIMED gateway; level requests by default, rising-edge requests when INT_ARB_EDGE_EN is defined.
module int_gateway
  import int_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic irq,
  input  logic claim,
  input  logic complete,
  output logic pend
);
  gw_state_e state;
  logic req;
`ifdef INT_ARB_EDGE_EN
  logic irq_d;
  // delayed copy of the source line for rising-edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) irq_d <= 1'b0;
    else irq_d <= irq;
  end
  assign req = irq & ~irq_d;
`else
  assign req = irq;
`endif
  // gateway FSM; requests seen outside IDLE are dropped, pend mirrors the PEND state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= GW_IDLE;
      pend  <= 1'b0;
    end else begin
      unique case (state)
        GW_IDLE: if (req) begin
          state <= GW_PEND;
          pend  <= 1'b1;
        end
        GW_PEND: if (claim) begin
          state <= GW_CLAIMED;
          pend  <= 1'b0;
        end
        GW_CLAIMED: if (complete) state <= GW_IDLE;
        default: begin
          state <= GW_IDLE;
          pend  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/int_arb.sv
// int_arb: interrupt arbiter with per-source gateways, priority/enable/threshold registers and claim/complete; INT_ARB_EDGE_EN selects edge-triggered sources.
module int_arb
  import int_pkg::*;
#(
  parameter int SRC_NUM = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [SRC_NUM-1:0] src_irq,
  input  logic               reg_vld,
  input  logic               reg_wr,
  input  logic [7:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic               reg_rdy,
  output logic [31:0]        reg_rdata,
  output logic               ext_irq
);
  logic [PRIO_W-1:0] prio [1:SRC_NUM];
  logic [SRC_NUM:1]  en;
  logic [SRC_NUM:1]  pend;
  logic [PRIO_W-1:0] thr;
  logic [ID_W-1:0]   best_id;
  logic [ID_W-1:0]   best_nxt;
  logic [PRIO_W-1:0] best_p;
  logic [31:0]       rdata_nxt;
  logic rd, wr, claim_rd, cmp_wr;
  assign rd       = reg_vld & ~reg_wr;
  assign wr       = reg_vld & reg_wr;
  assign claim_rd = rd && reg_addr == ADDR_CLAIM;
  assign cmp_wr   = wr && reg_addr == ADDR_CLAIM;
  for (genvar g = 1; g <= SRC_NUM; g++) begin : gw
    int_gateway u_gw (
      .clk      (clk),
      .rstn     (rstn),
      .irq      (src_irq[g-1]),
      .claim    (claim_rd && best_id == ID_W'(g)),
      .complete (cmp_wr && reg_wdata == 32'(g)),
      .pend     (pend[g])
    );
  end
  // highest eligible priority wins, lowest ID on ties; the ID being claimed this cycle is excluded so it never wins twice
  always_comb begin
    best_nxt = '0;
    best_p   = '0;
    for (int i = 1; i <= SRC_NUM; i++) begin
      if (pend[i] && en[i] && prio[i] > thr && prio[i] > best_p && !(claim_rd && best_id == ID_W'(i))) begin
        best_nxt = ID_W'(i);
        best_p   = prio[i];
      end
    end
  end
  // writable configuration registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 1; i <= SRC_NUM; i++) prio[i] <= '0;
      en  <= '0;
      thr <= '0;
    end else if (wr) begin
      for (int i = 1; i <= SRC_NUM; i++) if (reg_addr == prio_addr(i)) prio[i] <= reg_wdata[PRIO_W-1:0];
      if (reg_addr == ADDR_EN) en <= reg_wdata[SRC_NUM:1];
      if (reg_addr == ADDR_THR) thr <= reg_wdata[PRIO_W-1:0];
    end
  end
  // read mux; unmapped addresses return 0
  always_comb begin
    rdata_nxt = '0;
    for (int i = 1; i <= SRC_NUM; i++) if (reg_addr == prio_addr(i)) rdata_nxt = 32'(prio[i]);
    rdata_nxt = reg_addr == ADDR_PEND  ? 32'({pend, 1'b0}) :
                reg_addr == ADDR_EN    ? 32'({en, 1'b0}) :
                reg_addr == ADDR_THR   ? 32'(thr) :
                reg_addr == ADDR_CLAIM ? 32'(best_id) : rdata_nxt;
  end
  // registered access response, winner and interrupt line
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      reg_rdy   <= 1'b0;
      reg_rdata <= '0;
      best_id   <= '0;
      ext_irq   <= 1'b0;
    end else begin
      reg_rdy   <= reg_vld;
      reg_rdata <= rd ? rdata_nxt : '0;
      best_id   <= best_nxt;
      ext_irq   <= best_nxt != '0;
    end
  end
endmodule

// File: tb/tb_int_arb.sv
// tb_int_arb: directed register/interrupt scenarios with a scoreboard checking every access response.
module tb_int_arb;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  src_irq = '0;
  logic        reg_vld = 1'b0;
  logic        reg_wr = 1'b0;
  logic [7:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic        reg_rdy;
  logic [31:0] reg_rdata;
  logic        ext_irq;
  int total = 0;
  int bad = 0;
  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb[$];
  sb_t ent;

  int_arb #(.SRC_NUM(8), .PRIO_W(3)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .src_irq   (src_irq),
    .reg_vld   (reg_vld),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdy   (reg_rdy),
    .reg_rdata (reg_rdata),
    .ext_irq   (ext_irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn && reg_rdy) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rdy got=%h want=no response", reg_rdata);
      end else begin
        ent = sb.pop_front();
        if (reg_rdata !== ent.exp) begin
          bad++;
          $display("FAIL %s got=%h want=%h", ent.name, reg_rdata, ent.exp);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic acc(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [31:0] e, input string n);
    reg_vld = 1'b1;
    reg_wr = w;
    reg_addr = a;
    reg_wdata = d;
    sb.push_back('{n, e});
    cyc(1);
    reg_vld = 1'b0;
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
    acc(1'b1, a, d, 32'h0, "write_rdata");
  endtask

  task automatic rd_reg(input logic [7:0] a, input logic [31:0] e, input string n);
    acc(1'b0, a, 32'h0, e, n);
  endtask

  task automatic pulse(input logic [7:0] m);
    src_irq = m;
    cyc(1);
    src_irq = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    rstn = 1'b1;
    chk("rst_ext_irq", 32'(ext_irq), 0);
    chk("rst_rdy", 32'(reg_rdy), 0);
    rd_reg(8'h40, 32'h0, "rst_pend");
    rd_reg(8'h44, 32'h0, "rst_en");
    rd_reg(8'h48, 32'h0, "rst_thr");
    rd_reg(8'h0C, 32'h0, "rst_prio3");
    rd_reg(8'h4C, 32'h0, "rst_claim_none");
    rd_reg(8'h50, 32'h0, "unmapped_50");
    rd_reg(8'h00, 32'h0, "unmapped_00");
    wr_reg(8'h44, 32'hFFFF_FFFF);
    rd_reg(8'h44, 32'h0000_01FE, "en_unused_bits");
    wr_reg(8'h0C, 32'hFFFF_FFFF);
    rd_reg(8'h0C, 32'h7, "prio_width");

    wr_reg(8'h0C, 32'd2);
    wr_reg(8'h44, 32'h08);
    wr_reg(8'h48, 32'd0);
    pulse(8'h04);
    cyc(1);
    chk("setup_ext_irq", 32'(ext_irq), 1);
    rd_reg(8'h40, 32'h08, "setup_pend");
    rd_reg(8'h4C, 32'd3, "setup_claim");
    chk("setup_ext_irq_drop", 32'(ext_irq), 0);
    rd_reg(8'h40, 32'h0, "setup_pend_clear");
    wr_reg(8'h4C, 32'd3);

    wr_reg(8'h08, 32'd4);
    wr_reg(8'h14, 32'd4);
    wr_reg(8'h44, 32'h24);
    pulse(8'h12);
    cyc(2);
    rd_reg(8'h40, 32'h24, "tie_pend");
    rd_reg(8'h4C, 32'd2, "tie_claim1");
    rd_reg(8'h4C, 32'd5, "tie_claim2");
    rd_reg(8'h4C, 32'd0, "tie_claim3");
    wr_reg(8'h4C, 32'd2);
    wr_reg(8'h4C, 32'd5);

    wr_reg(8'h48, 32'd2);
    wr_reg(8'h04, 32'd2);
    wr_reg(8'h44, 32'h02);
    pulse(8'h01);
    cyc(3);
    chk("thr_block", 32'(ext_irq), 0);
    wr_reg(8'h48, 32'd1);
    chk("thr_not_yet", 32'(ext_irq), 0);
    cyc(1);
    chk("thr_pass", 32'(ext_irq), 1);
    rd_reg(8'h4C, 32'd1, "thr_claim");
    wr_reg(8'h4C, 32'd1);

    wr_reg(8'h1C, 32'd5);
    wr_reg(8'h44, 32'h80);
    pulse(8'h40);
    cyc(1);
    chk("dis_ext_irq_on", 32'(ext_irq), 1);
    wr_reg(8'h44, 32'h00);
    cyc(1);
    chk("dis_ext_irq_off", 32'(ext_irq), 0);
    rd_reg(8'h40, 32'h80, "dis_still_pend");
    wr_reg(8'h44, 32'h80);
    cyc(1);
    chk("reen_ext_irq", 32'(ext_irq), 1);
    rd_reg(8'h4C, 32'd7, "reen_claim");
    wr_reg(8'h4C, 32'd7);

    wr_reg(8'h10, 32'd3);
    wr_reg(8'h44, 32'h10);
    src_irq = 8'h08;
    cyc(2);
    rd_reg(8'h4C, 32'd4, "cmp_claim4");
    wr_reg(8'h4C, 32'd6);
    wr_reg(8'h4C, 32'd0);
    wr_reg(8'h4C, 32'd9);
    rd_reg(8'h40, 32'h0, "cmp_ignored_pend");
    chk("cmp_ignored_irq", 32'(ext_irq), 0);
    wr_reg(8'h4C, 32'd4);
    cyc(1);
`ifdef INT_ARB_EDGE_EN
    rd_reg(8'h40, 32'h0, "cmp_edge_pend");
    rd_reg(8'h4C, 32'd0, "cmp_edge_claim");
    src_irq = '0;
`else
    rd_reg(8'h40, 32'h10, "cmp_level_pend");
    rd_reg(8'h4C, 32'd4, "cmp_level_claim");
    src_irq = '0;
    wr_reg(8'h4C, 32'd4);
`endif

    wr_reg(8'h04, 32'd5);
    wr_reg(8'h08, 32'd3);
    wr_reg(8'h48, 32'd0);
    wr_reg(8'h44, 32'h06);
    pulse(8'h01);
    cyc(1);
    rd_reg(8'h4C, 32'd1, "rst_mid_claim1");
    pulse(8'h02);
    cyc(1);
    chk("rst_mid_irq", 32'(ext_irq), 1);
    reg_vld = 1'b1;
    reg_wr = 1'b0;
    reg_addr = 8'h4C;
    #2;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    reg_vld = 1'b0;
    chk("rst_mid_rdy", 32'(reg_rdy), 0);
    chk("rst_mid_rdata", reg_rdata, 0);
    chk("rst_mid_ext", 32'(ext_irq), 0);
    cyc(1);
    rstn = 1'b1;
    cyc(1);
    chk("rst_rel_rdy", 32'(reg_rdy), 0);
    chk("rst_rel_ext", 32'(ext_irq), 0);
    rd_reg(8'h40, 32'h0, "rst_rel_pend");
    rd_reg(8'h44, 32'h0, "rst_rel_en");
    rd_reg(8'h04, 32'h0, "rst_rel_prio1");
    rd_reg(8'h4C, 32'h0, "rst_rel_claim");
    cyc(2);
    chk("sb_drain", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/int_arb.md
INT_ARB -- requirements
Module: int_arb

Interface
REQ-001 Parameter SRC_NUM, default 8, meaning number of external interrupt sources; IDs 1..SRC_NUM, range 1..15, ID 0 means "none".
REQ-002 Parameter PRIO_W, default 3, meaning priority field width; priority 0 means never interrupt.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 src_irq  input  SRC_NUM  raw source lines; bit i-1 is ID i; synchronous to clk.
REQ-006 reg_vld  input  1  register access request, one-cycle pulse per access.
REQ-007 reg_wr  input  1  1 write, 0 read; sampled with reg_vld.
REQ-008 reg_addr  input  8  byte address, word aligned.
REQ-009 reg_wdata  input  32  write data.
REQ-010 reg_rdy  output  1  access done; valid cycle for reg_rdata.
REQ-011 reg_rdata  output  32  read data; 0 for writes and unmapped addresses.
REQ-012 ext_irq  output  1  external interrupt request to the core interrupt controller (its ext_irq input).

Function
REQ-013 Register map: 0x04*i priority of ID i (bits PRIO_W-1:0, RW); 0x40 pending (RO, bit i = ID i); 0x44 enable (RW, bit i = ID i); 0x48 threshold (RW, PRIO_W bits); 0x4C claim (read)/complete (write). Bit 0 of pending/enable SHALL read 0. Unused bits SHALL read 0.
REQ-014 reg_rdy SHALL assert exactly one cycle after each reg_vld cycle; back-to-back accesses SHALL be accepted every cycle.
REQ-015 Each source SHALL have a gateway FSM: IDLE -> PEND on request; PEND -> CLAIMED on claim of that ID; CLAIMED -> IDLE on complete write of that ID.
REQ-016 Requests arriving in PEND or CLAIMED SHALL be ignored, with no queuing.
REQ-017 Arbitration SHALL select, among PEND sources with enable=1 and priority > threshold, the highest priority; ties go to the lowest ID.
REQ-018 Winner ID SHALL be registered (best_id), one cycle after any input change; ext_irq SHALL equal (best_id != 0), registered.
REQ-019 A claim read SHALL return best_id as held in the access cycle, move that source to CLAIMED and clear its pending bit. If best_id is 0, it SHALL return 0 with no state change.
REQ-020 A source entering PEND in the same cycle as a claim SHALL NOT be the claim result; it competes from the next cycle.
REQ-021 A complete write with an ID that is not in CLAIMED, or that is 0 or greater than SRC_NUM, SHALL be ignored.
REQ-022 Priority, enable and threshold writes SHALL take effect on arbitration the next cycle.
REQ-023 Disabling a PEND source SHALL keep it pending; it SHALL be arbitrated again when re-enabled.

Reset
REQ-024 On rstn low: all gateways IDLE; priorities, enable, threshold and best_id 0; ext_irq, reg_rdy and reg_rdata 0. A request in flight SHALL be dropped, with no reg_rdy after reset release.

Configuration
REQ-025 Macro INT_ARB_EDGE_EN. When defined: per-source rising-edge detect, request = src_irq & ~src_irq_d, with src_irq_d reset to 0.
REQ-026 When INT_ARB_EDGE_EN is not defined: level request = src_irq, and a source still high at complete SHALL re-enter PEND the next cycle.

Structure
REQ-027 Package int_pkg SHALL hold the register offsets (0x40, 0x44, 0x48, 0x4C) and the gateway state encoding (IDLE, PEND, CLAIMED).
REQ-028 Sub-module int_gateway SHALL be one source's FSM plus its edge/level logic, instantiated SRC_NUM times. Arbitration and the register file SHALL live in int_arb.

Verification
REQ-029 Setup: prio ID3=2, enable 0x08, threshold 0; pulse src_irq[2] -> pending=0x08, ext_irq=1 within 2 cycles; claim reads 3; ext_irq=0 the next cycle.
REQ-030 Tie-break: prio ID2=ID5=4, both enabled and pending -> claim returns 2, second claim returns 5, third claim returns 0.
REQ-031 Threshold: prio ID1=2, threshold=2 -> ext_irq stays 0; write threshold=1 -> ext_irq=1 two cycles later.
REQ-032 Complete handling: while ID4 is CLAIMED, write complete=6 (not claimed) -> no change. Write complete=4 with level held high -> ID4 pending again, or with INT_ARB_EDGE_EN defined and no new edge -> not pending.
REQ-033 Reset mid-operation: ID1 CLAIMED, ID2 PEND, rstn low during a claim read -> all outputs 0, pending=0, no reg_rdy after reset release.
